// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared encodings and seed helpers for the LED step sequencer
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'b00,
    MODE_ROTATE = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BAR    = 2'b11
  } mode_e;

  typedef enum logic {
    B_UP   = 1'b0,
    B_DOWN = 1'b1
  } bounce_state_e;

  // Every seed is either all-zero or a lone bit 0, so the LSB fully describes it.
  function automatic logic seed_lsb(input mode_e m);
    return (m == MODE_ROTATE) || (m == MODE_BOUNCE);
  endfunction

  function automatic logic [31:0] seed_value(input mode_e m, input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return {31'd0, seed_lsb(m)} & mask;
  endfunction

endpackage

// File: rtl/led_step_sequencer_tick_edge_sync.sv
// rtl/led_step_sequencer_tick_edge_sync.sv - tick_edge_sync: synchronise i_tick and flag its rising edge
module tick_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clkPin,
  input  logic i_rst_n,
  input  logic i_tick,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_tick};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge i_clkPin or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign o_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/led_step_sequencer.sv
// rtl/led_step_sequencer.sv - steps an LED pattern once per divided-clock edge
// LED_SEQ_BOUNCE_EN builds the ping-pong FSM for mode 10; otherwise mode 10 rotates.
module led_step_sequencer #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clkPin,
  input  logic             i_rst_n,
  input  logic             i_ena,
  input  logic             i_tick,
  input  logic [1:0]       i_mode,
  input  logic             i_dir,
  input  logic             i_pause,
  output logic [WIDTH-1:0] o_leds,
  output logic             o_step,
  output logic             o_wrap
);
  import led_seq_pkg::*;

  localparam logic [WIDTH-1:0] LED_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             tick_edge;
  mode_e            mode_in;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] leds_q, leds_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] seed;
  logic             advance;

  tick_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clkPin (i_clkPin),
    .i_rst_n  (i_rst_n),
    .i_tick   (i_tick),
    .o_edge   (tick_edge)
  );

  assign mode_in = mode_e'(i_mode);
  assign seed    = {{(WIDTH-1){1'b0}}, seed_lsb(mode_in)};
  assign advance = tick_edge & i_ena & ~i_pause;

`ifdef LED_SEQ_BOUNCE_EN
  bounce_state_e state_q, state_d;
`endif

  always_comb begin
    mode_d = mode_q;
    leds_d = leds_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
`ifdef LED_SEQ_BOUNCE_EN
    state_d = state_q;
`endif
    if (i_ena) begin
      step_d = tick_edge;
      // A mode change reloads the seed and swallows any coincident step.
      if (mode_in != mode_q) begin
        mode_d = mode_in;
        leds_d = seed;
`ifdef LED_SEQ_BOUNCE_EN
        state_d = B_UP;
`endif
      end else if (advance) begin
        case (mode_q)
          MODE_COUNT: begin
            if (i_dir) begin
              leds_d = leds_q + LED_ONE;
              wrap_d = &leds_q;
            end else begin
              leds_d = leds_q - LED_ONE;
              wrap_d = ~|leds_q;
            end
          end
`ifdef LED_SEQ_BOUNCE_EN
          MODE_ROTATE: begin
`else
          MODE_ROTATE, MODE_BOUNCE: begin
`endif
            if (i_dir) begin
              leds_d = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
              wrap_d = leds_q[WIDTH-1];
            end else begin
              leds_d = {leds_q[0], leds_q[WIDTH-1:1]};
              wrap_d = leds_q[0];
            end
          end
`ifdef LED_SEQ_BOUNCE_EN
          MODE_BOUNCE: begin
            if (!$onehot(leds_q)) begin
              leds_d  = LED_ONE;
              state_d = B_UP;
            end else if (state_q == B_UP) begin
              leds_d = leds_q << 1;
              if (leds_q[WIDTH-2]) state_d = B_DOWN;
            end else begin
              leds_d = leds_q >> 1;
              if (leds_q[1]) begin
                state_d = B_UP;
                wrap_d  = 1'b1;
              end
            end
          end
`endif
          default: begin
            if (&leds_q) begin
              leds_d = '0;
              wrap_d = 1'b1;
            end else begin
              leds_d = (leds_q << 1) | LED_ONE;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clkPin or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q <= MODE_COUNT;
      leds_q <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      leds_q <= leds_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef LED_SEQ_BOUNCE_EN
  always_ff @(posedge i_clkPin or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= B_UP;
    else          state_q <= state_d;
  end
`endif

  assign o_leds = leds_q;
  assign o_step = step_q;
  assign o_wrap = wrap_q;

endmodule

// File: tb/tb_led_step_sequencer.sv
// tb/tb_led_step_sequencer.sv - self-checking bench for led_step_sequencer
module tb_led_step_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic         tick;
  logic [1:0]   mode;
  logic         dir;
  logic         pause;
  logic [W-1:0] leds;
  logic         step;
  logic         wrap;

  int checks = 0;
  int errors = 0;

  // Reference model: raw mode plus an abstract position within that mode's cycle.
  int m_mode = 0;
  int m_pos  = 0;

  led_step_sequencer #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .i_clkPin (clk),
    .i_rst_n  (rst_n),
    .i_ena    (ena),
    .i_tick   (tick),
    .i_mode   (mode),
    .i_dir    (dir),
    .i_pause  (pause),
    .o_leds   (leds),
    .o_step   (step),
    .o_wrap   (wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic int eff_mode(input int m);
`ifdef LED_SEQ_BOUNCE_EN
    return m;
`else
    return (m == 2) ? 1 : m;
`endif
  endfunction

  function automatic logic [W-1:0] model_leds();
    logic [W-1:0] one = 1;
    case (eff_mode(m_mode))
      0:       return W'(m_pos);
      1:       return one << m_pos;
      2:       return one << ((m_pos < W) ? m_pos : 2 * (W - 1) - m_pos);
      default: return (one << m_pos) - one;
    endcase
  endfunction

  function automatic logic model_advance(input logic d);
    int period;
    case (eff_mode(m_mode))
      0:       period = 1 << W;
      1:       period = W;
      2:       period = 2 * (W - 1);
      default: period = W + 1;
    endcase
    // Bounce and bar only run forward; count and rotate honour direction.
    if (d || eff_mode(m_mode) >= 2) begin
      m_pos = (m_pos + 1) % period;
      return m_pos == 0;
    end
    m_pos = (m_pos + period - 1) % period;
    return m_pos == period - 1;
  endfunction

  task automatic model_next(output logic [W-1:0] el, output logic es, output logic ew);
    ew = 1'b0;
    if (ena && !pause) ew = model_advance(dir);
    es = ena;
    el = model_leds();
  endtask

  task automatic apply(input int m, input logic d, input logic p, input logic e);
    @(negedge clk);
    mode  = 2'(m);
    dir   = d;
    pause = p;
    ena   = e;
    if (e && m != m_mode) begin
      m_mode = m;
      m_pos  = 0;
    end
  endtask

  // One i_tick pulse; the result must show on the third sampling edge and last one cycle.
  task automatic tick_check(input logic [W-1:0] el, input logic es, input logic ew, input string nm);
    @(negedge clk);
    tick = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk({nm, " early step"}, 32'(step), 32'd0);
    end
    @(negedge clk);
    chk({nm, " step"}, 32'(step), 32'(es));
    chk({nm, " wrap"}, 32'(wrap), 32'(ew));
    chk({nm, " leds"}, 32'(leds), 32'(el));
    @(negedge clk);
    chk({nm, " step width"}, 32'({step, wrap}), 32'd0);
    tick = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic tick_model(input string nm);
    logic [W-1:0] el;
    logic         es, ew;
    model_next(el, es, ew);
    tick_check(el, es, ew, nm);
  endtask

  typedef struct {
    int           m;
    logic         d;
    logic         p;
    logic         e;
    logic [W-1:0] el;
    logic         es;
    logic         ew;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [W-1:0] el;
    logic         es, ew;

    vecs[0]  = '{0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[1]  = '{0, 1'b1, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};
    vecs[2]  = '{0, 1'b1, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0};
    vecs[3]  = '{0, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};
    vecs[4]  = '{0, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[5]  = '{0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1};
    vecs[7]  = '{0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[8]  = '{3, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[9]  = '{3, 1'b1, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0};
    vecs[10] = '{3, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
    vecs[11] = '{3, 1'b1, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0};
    vecs[12] = '{1, 1'b0, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1};
    vecs[13] = '{1, 1'b0, 1'b0, 1'b1, 8'h40, 1'b1, 1'b0};
    vecs[14] = '{1, 1'b1, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};
    vecs[15] = '{1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1};

    rst_n = 1'b0; ena = 1'b0; tick = 1'b0; mode = 2'd0; dir = 1'b1; pause = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset outputs", 32'({leds, step, wrap}), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      apply(vecs[i].m, vecs[i].d, vecs[i].p, vecs[i].e);
      model_next(el, es, ew);
      tick_check(vecs[i].el, vecs[i].es, vecs[i].ew, $sformatf("vec%0d", i));
    end

    // Count up through the full range to the 0xFF -> 0x00 wrap.
    apply(3, 1'b1, 1'b0, 1'b1);
    apply(0, 1'b1, 1'b0, 1'b1);
    repeat (255) tick_model("count run");
    chk("count preload", 32'(leds), 32'hFF);
    tick_model("count wrap");

    // Mode 10 through a full bounce (or rotate) period.
    apply(2, 1'b1, 1'b0, 1'b1);
    repeat (16) tick_model("mode10 run");

    // Mode switch landing on the same cycle as a detected edge.
    apply(0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    tick = 1'b1;
    repeat (2) @(negedge clk);
    mode = 2'd1;
    @(negedge clk);
    chk("switch leds", 32'(leds), 32'h01);
    chk("switch step", 32'(step), 32'd1);
    chk("switch wrap", 32'(wrap), 32'd0);
    m_mode = 1;
    m_pos  = 0;
    @(negedge clk);
    tick = 1'b0;
    repeat (4) @(negedge clk);

    // Asynchronous reset mid-pattern at 0x20, then reseed on release.
    apply(3, 1'b1, 1'b0, 1'b1);
    apply(2, 1'b1, 1'b0, 1'b1);
    repeat (5) tick_model("to 0x20");
    chk("mid value", 32'(leds), 32'h20);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async reset", 32'({leds, step, wrap}), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    m_mode = 2;
    m_pos  = 0;
    @(negedge clk);
    chk("reseed after reset", 32'(leds), 32'h01);
    repeat (3) tick_model("post reset");

    // Randomised inputs between ticks, compared against the model.
    for (int i = 0; i < 150; i++) begin
      apply(int'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) != 0));
      tick_model($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
